// File: rtl/processor.sv
// 8-bit accumulator processor with 256x8 unified RAM and byte-serial loader.
// Optional Z/C flags and JZ/JC are enabled by defining PROC_FLAGS_EN.
module processor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam logic [2:0] S_LOAD_ADDR = 3'd0;
  localparam logic [2:0] S_LOAD_DATA = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h03;
  localparam logic [7:0] OP_SUBI = 8'h04;
  localparam logic [7:0] OP_ANDI = 8'h05;
  localparam logic [7:0] OP_ORI  = 8'h06;
  localparam logic [7:0] OP_XORI = 8'h07;
  localparam logic [7:0] OP_JMP  = 8'h08;
  localparam logic [7:0] OP_LDA  = 8'h09;
  localparam logic [7:0] OP_STA  = 8'h0A;
`ifdef PROC_FLAGS_EN
  localparam logic [7:0] OP_JZ   = 8'h0B;
  localparam logic [7:0] OP_JC   = 8'h0C;
`endif
  localparam logic [7:0] OP_HALT = 8'hFF;

  logic [7:0] mem [256];

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] base_q, base_d;
  logic [7:0] ld_ptr_q, ld_ptr_d;
  logic [7:0] dout_q, dout_d;

  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] opnd;
  logic [7:0] rd_data;
  logic [7:0] pc_inc;
  logic       acc_we;
  logic [7:0] acc_new;

  assign opnd     = mem[pc_q];
  assign rd_data  = mem[opnd];
  assign pc_inc   = pc_q + 8'd1;
  assign data_out = dout_q;

`ifdef PROC_FLAGS_EN
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [8:0] sum9;
  logic [8:0] diff9;
  assign sum9  = {1'b0, acc_q} + {1'b0, opnd};
  assign diff9 = {1'b0, acc_q} - {1'b0, opnd};
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    base_d    = base_q;
    ld_ptr_d  = ld_ptr_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = ld_ptr_q;
    mem_wdata = data_in;
    acc_we    = 1'b0;
    acc_new   = acc_q;
`ifdef PROC_FLAGS_EN
    z_d       = z_q;
    c_d       = c_q;
`endif
    unique case (state_q)
      S_LOAD_ADDR: begin
        base_d   = data_in;
        ld_ptr_d = data_in;
        state_d  = S_LOAD_DATA;
      end
      S_LOAD_DATA: begin
        if (start) begin
          pc_d    = base_q;
          state_d = S_FETCH;
        end else begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + 8'd1;
        end
      end
      S_FETCH: begin
        ir_d    = mem[pc_q];
        pc_d    = pc_inc;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q)
          OP_LDI:  begin pc_d = pc_inc; acc_we = 1'b1; acc_new = opnd; end
          OP_ADDI: begin pc_d = pc_inc; acc_we = 1'b1; acc_new = acc_q + opnd; end
          OP_SUBI: begin pc_d = pc_inc; acc_we = 1'b1; acc_new = acc_q - opnd; end
          OP_ANDI: begin pc_d = pc_inc; acc_we = 1'b1; acc_new = acc_q & opnd; end
          OP_ORI:  begin pc_d = pc_inc; acc_we = 1'b1; acc_new = acc_q | opnd; end
          OP_XORI: begin pc_d = pc_inc; acc_we = 1'b1; acc_new = acc_q ^ opnd; end
          OP_LDA:  begin pc_d = pc_inc; acc_we = 1'b1; acc_new = rd_data; end
          OP_JMP:  pc_d = opnd;
          OP_STA: begin
            pc_d      = pc_inc;
            mem_we    = 1'b1;
            mem_waddr = opnd;
            mem_wdata = acc_q;
          end
          OP_OUT:  dout_d = acc_q;
          OP_HALT: state_d = S_HALTED;
`ifdef PROC_FLAGS_EN
          OP_JZ:   pc_d = z_q ? opnd : pc_inc;
          OP_JC:   pc_d = c_q ? opnd : pc_inc;
`endif
          default: ;
        endcase
      end
      S_HALTED: ;
      default: state_d = S_LOAD_ADDR;
    endcase
`ifdef PROC_FLAGS_EN
    if (acc_we) z_d = (acc_new == 8'h00);
    if (state_q == S_EXEC) begin
      case (ir_q)
        OP_ADDI: c_d = sum9[8];
        OP_SUBI: c_d = diff9[8];
        OP_ANDI, OP_ORI, OP_XORI: c_d = 1'b0;
        default: ;
      endcase
    end
`endif
  end

  assign acc_d = acc_we ? acc_new : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD_ADDR;
      pc_q     <= 8'h00;
      acc_q    <= 8'h00;
      ir_q     <= 8'h00;
      base_q   <= 8'h00;
      ld_ptr_q <= 8'h00;
      dout_q   <= 8'h00;
`ifdef PROC_FLAGS_EN
      z_q      <= 1'b0;
      c_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      ir_q     <= ir_d;
      base_q   <= base_d;
      ld_ptr_q <= ld_ptr_d;
      dout_q   <= dout_d;
`ifdef PROC_FLAGS_EN
      z_q      <= z_d;
      c_q      <= c_d;
`endif
    end
  end

  // RAM is never cleared; reset only suppresses the write on that edge
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_processor.sv
// Directed self-checking bench for the accumulator processor.
module tb_processor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] pq [$];

  processor dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic load_run();
    start = 1'b0;
    foreach (pq[i]) begin
      data_in = pq[i];
      tick(1);
    end
    start = 1'b1;
    tick(1);
    data_in = 8'h00;
  endtask

  initial begin
    #2;
    do_reset();
    check("reset_out", data_out, 8'h00);

    pq = '{8'h55, 8'h01, 8'h0A, 8'h02, 8'hA0, 8'h03, 8'hFF};
    load_run();
    tick(5);
    check("add_pre", data_out, 8'h00);
    tick(1);
    check("add_out", data_out, 8'hAA);
    tick(10);
    check("add_hold", data_out, 8'hAA);

    do_reset();
    pq = '{8'h10, 8'h01, 8'h05, 8'h04, 8'h07, 8'h03, 8'hFF};
    load_run();
    tick(6);
    check("sub_wrap", data_out, 8'hFE);

    do_reset();
    pq = '{8'h20, 8'h01, 8'h3C, 8'h0A, 8'h80, 8'h01, 8'h00,
           8'h09, 8'h80, 8'h03, 8'hFF};
    load_run();
    tick(9);
    check("sta_pre", data_out, 8'h00);
    tick(1);
    check("sta_lda", data_out, 8'h3C);

    do_reset();
    pq = '{8'h30, 8'h01, 8'h01, 8'h03, 8'h02, 8'h01, 8'h08, 8'h32};
    load_run();
    tick(4);
    check("loop_first", data_out, 8'h01);
    for (int i = 2; i <= 257; i++) begin
      logic [7:0] e;
      e = i[7:0];
      tick(5);
      check("loop_hold", data_out, e - 8'd1);
      tick(1);
      check("loop_cnt", data_out, e);
    end
    tick(3);
    rst = 1'b1;
    tick(1);
    check("mid_rst", data_out, 8'h00);
    rst = 1'b0;
    pq = '{8'h10, 8'h01, 8'h05, 8'h04, 8'h07, 8'h03, 8'hFF};
    load_run();
    tick(6);
    check("post_rst_base", data_out, 8'hFE);

    do_reset();
    pq = '{8'hFE, 8'h01, 8'h77, 8'h03, 8'hFF};
    load_run();
    tick(3);
    check("wrap_pre", data_out, 8'h00);
    tick(1);
    check("wrap_out", data_out, 8'h77);

    do_reset();
    pq = '{8'h40, 8'h01, 8'hFF, 8'h02, 8'h01, 8'h0C, 8'h48,
           8'hFF, 8'h03, 8'hFF};
    load_run();
    tick(10);
    check("jc_prog", data_out, 8'h00);

    do_reset();
    pq = '{8'h60, 8'h01, 8'h42, 8'h0B, 8'h03, 8'hFF};
    load_run();
    tick(6);
`ifdef PROC_FLAGS_EN
    check("jz_fall", data_out, 8'h00);
`else
    check("op0b_nop", data_out, 8'h42);
`endif

    do_reset();
    pq = '{8'h70, 8'h01, 8'h00, 8'h0B, 8'h76, 8'h03, 8'hFF,
           8'h01, 8'h99, 8'h03, 8'hFF};
    load_run();
    tick(8);
`ifdef PROC_FLAGS_EN
    check("jz_taken", data_out, 8'h99);
`else
    check("jz_nop_path", data_out, 8'h00);
`endif

    do_reset();
    pq = '{8'h90, 8'h01, 8'h03, 8'h0A, 8'h96, 8'h01, 8'h5A,
           8'h00, 8'hFF};
    load_run();
    tick(8);
    check("self_mod", data_out, 8'h5A);

    do_reset();
    pq = '{8'hA0, 8'h01, 8'h0F, 8'h05, 8'h3C, 8'h06, 8'h40,
           8'h07, 8'hFF, 8'h03, 8'hFF};
    load_run();
    tick(10);
    check("logic_ops", data_out, 8'hB3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
